// File: rtl/alu16_rr_arbiter.sv
// Two-requester round-robin front end for one shared alu16, with a single
// registered result slot routed back to the requester that issued the op.

module alu16 #(
   parameter int DATA_W = 16
) (
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   input  logic        [2:0]        op,
   output logic signed [DATA_W-1:0] z
);
   localparam logic signed [DATA_W-1:0] ONE = 1;

   always_comb begin
      z = '0;
      case (op)
         3'b000: z = a | b;
         3'b001: z = a & b;
         3'b010: z = a ^ b;
         3'b011: z = ~(a & b);
         3'b100: z = b;
         3'b101: z = a + ONE;
         3'b110: z = a + b;
         3'b111: z = a - b;
         default: z = '0;
      endcase
   end
endmodule

module alu16_rr_arbiter #(
   parameter logic RR_INIT = 1'b0,
   parameter int   DATA_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s0_valid,
   output logic                     s0_ready,
   input  logic signed [DATA_W-1:0] s0_a,
   input  logic signed [DATA_W-1:0] s0_b,
   input  logic        [2:0]        s0_op,
   input  logic                     s1_valid,
   output logic                     s1_ready,
   input  logic signed [DATA_W-1:0] s1_a,
   input  logic signed [DATA_W-1:0] s1_b,
   input  logic        [2:0]        s1_op,
   output logic                     r0_valid,
   input  logic                     r0_ready,
   output logic        [DATA_W-1:0] r0_z,
   output logic                     r1_valid,
   input  logic                     r1_ready,
   output logic        [DATA_W-1:0] r1_z,
   output logic                     busy,
   output logic        [15:0]       cnt0,
   output logic        [15:0]       cnt1
);
   logic                     vld_p1;
   logic                     owner_p1;
   logic signed [DATA_W-1:0] z_p1;
   logic                     rr_ptr;
   logic                     drain;
   logic                     slot_free;
   logic                     gnt;
   logic signed [DATA_W-1:0] alu_a;
   logic signed [DATA_W-1:0] alu_b;
   logic        [2:0]        alu_op;
   logic signed [DATA_W-1:0] alu_z;

   assign drain     = vld_p1 & (owner_p1 ? r1_ready : r0_ready);
   assign slot_free = !vld_p1 | drain;

   // rr_ptr only breaks ties; a lone requester always wins
   assign gnt      = (s0_valid & s1_valid) ? rr_ptr : s1_valid;
   assign s0_ready = !rst & slot_free & s0_valid & !gnt;
   assign s1_ready = !rst & slot_free & s1_valid & gnt;

   assign alu_a  = gnt ? s1_a  : s0_a;
   assign alu_b  = gnt ? s1_b  : s0_b;
   assign alu_op = gnt ? s1_op : s0_op;

   alu16 #(.DATA_W(DATA_W)) u_alu (
      .a  (alu_a),
      .b  (alu_b),
      .op (alu_op),
      .z  (alu_z)
   );

   // p0 -> p1: accepted command becomes the registered result slot
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1   <= 1'b0;
         owner_p1 <= 1'b0;
         z_p1     <= '0;
         rr_ptr   <= RR_INIT;
         cnt0     <= 16'd0;
         cnt1     <= 16'd0;
      end else begin
         if (s0_ready | s1_ready) begin
            z_p1     <= alu_z;
            owner_p1 <= gnt;
            vld_p1   <= 1'b1;
            rr_ptr   <= ~gnt;
         end else if (drain) begin
            vld_p1 <= 1'b0;
         end
         if (drain & !owner_p1) cnt0 <= cnt0 + 16'd1;
         if (drain &  owner_p1) cnt1 <= cnt1 + 16'd1;
      end
   end

   assign r0_valid = vld_p1 & !owner_p1;
   assign r1_valid = vld_p1 &  owner_p1;
   assign r0_z     = r0_valid ? z_p1 : '0;
   assign r1_z     = r1_valid ? z_p1 : '0;
   assign busy     = vld_p1;
endmodule

// File: doc/alu16_rr_arbiter.md
Name: alu16_rr_arbiter

Overview:
Shares one alu16 datapath (16-bit, 3-bit opcode) between two independent requesters. Each requester issues operand/opcode transactions over a valid/ready channel and gets its result back on its own valid/ready response channel. Arbitration is round-robin. There is a single registered result slot, giving 1-cycle latency and full throughput when responses drain every cycle. The block instantiates alu16 internally and sits between the two client FSMs and the shared ALU.

Parameters:
RR_INIT, 0, requester that holds priority after reset (0 or 1)

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous, active-high reset
s0_valid  input  1  requester 0 command valid
s0_ready  output  1  requester 0 command accepted this cycle
s0_a  input  16  requester 0 operand A, signed
s0_b  input  16  requester 0 operand B, signed
s0_op  input  3  requester 0 alu16 opcode
s1_valid, s1_ready, s1_a, s1_b, s1_op  same as above, for requester 1
r0_valid  output  1  result for requester 0 available
r0_ready  input  1  requester 0 takes result
r0_z  output  16  result data for requester 0
r1_valid, r1_ready, r1_z  same as above, for requester 1
busy  output  1  result slot occupied (slot_valid)
cnt0  output  16  completed responses delivered to requester 0
cnt1  output  16  completed responses delivered to requester 1

Behaviour:
- Reset (sync, rst=1 at posedge): slot_valid=0, slot_owner=0, slot_z=0, rr_ptr=RR_INIT, cnt0=cnt1=0.
  - After reset: all r*_valid=0, r*_z=0, busy=0, s*_ready=0.
  - Reset overrides every handshake in the same cycle.
  - A pending result is discarded and not counted.
- Result slot fields: {slot_valid, slot_owner, slot_z}.
- slot_free (combinational) = !slot_valid OR (r<owner>_valid AND r<owner>_ready) in the current cycle. A drain and a new accept in the same cycle are allowed.
- Arbitration, combinational, evaluated only when slot_free:
  - Both s0_valid and s1_valid high: grant requester rr_ptr.
  - Exactly one valid: grant that one.
  - None valid: no grant.
- s<g>_ready = slot_free AND s<g>_valid AND grant==g. The non-granted ready stays 0.
  - Ready depends on valid; requesters must not wait on ready before raising valid.
- Requester rule: a requester holding valid high with ready low must keep a/b/op stable. The arbiter latches nothing until accept.
- On accept (posedge with s<g>_valid & s<g>_ready):
  - slot_z <= alu16(s<g>_a, s<g>_b, s<g>_op); slot_owner <= g; slot_valid <= 1.
  - rr_ptr <= ~g, i.e. the other requester gets priority next.
  - Latency: accept at edge N gives r<g>_valid high in cycle N+1.
- On drain without a new accept: slot_valid <= 0; slot_owner and slot_z keep their values.
- r0_valid = slot_valid & (slot_owner==0); r1_valid = slot_valid & (slot_owner==1).
- r<k>_z = slot_z while r<k>_valid is high, otherwise 16'h0000.
- Backpressure: while r<owner>_ready=0 the slot holds and both s*_ready stay 0. This is true even for the non-owning requester; there is no bypass.
- ALU arithmetic follows alu16 (mod 2^16 wrap, no flags):
  - 000 OR, 001 AND, 010 XOR, 011 NAND
  - 100 pass B, 101 A+1, 110 A+B, 111 A-B
- Counters: cnt<k> increments on an r<k> handshake. It wraps from 16'hFFFF to 0.
- Throughput: 1 op/cycle when the owner's r*_ready is held high. Fairness: with both requesters streaming, grants alternate strictly.

Test Plan:
- Reset: assert rst 2 cycles with s0_valid=1 -> s0_ready=0, r0_valid=r1_valid=0, busy=0, cnt0=cnt1=0; first grant after rst deasserts goes to RR_INIT when both requesters are valid.
- Single op: s0 A=5 B=3 op=110, r0_ready=1 -> s0_ready=1 at cycle N; r0_valid=1, r0_z=8 at N+1; r1_valid=0; cnt0=1 at N+2.
- Contention (RR_INIT=0): s0 A=16'h7FFF op=101 and s1 A=3 B=5 op=111 both valid, r*_ready=1 -> r0_z=16'h8000 at N+1, r1_z=16'hFFFE at N+2; next contention grants s0 first.
- Backpressure: result owned by 1, r1_ready=0 for 3 cycles with s0_valid=1 -> s0_ready=0, r1_z stable, busy=1; raising r1_ready gives a same-cycle drain and s0 accept, with r0_valid the following cycle.
- Streaming: s0 and s1 valid continuously for 8 ops each, all r*_ready=1 -> alternating grants 0,1,0,1..., one result per cycle, cnt0=cnt1=8; plus a wrap check: cnt0 preset to 16'hFFFF via 65535 ops (or forced), next handshake -> 0.
- Reset mid-operation: slot valid for requester 0 with r0_ready=0, assert rst -> next cycle r0_valid=0, busy=0, cnt0 unchanged at 0 after reset, rr_ptr=RR_INIT.
